// File: rtl/if_stage.sv
`default_nettype none
// if_stage: instruction-fetch stage with PC register, IF/ID pipeline register and branch flush.
// Optional macro IF_STAGE_PERF_CNT_EN adds saturating fetch/flush counters.
// Revision: 1.0
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  localparam logic [31:0] c_pc_rst = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] c_nop    = 32'h0000_0000;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_pc;
  logic        w_fetch;
  logic [1:0]  w_unused_tgt_lsb;

  // Wraps modulo 2^32 by construction of the 32-bit adder.
  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_branch_pc      = {branch_target[31:2], 2'b00};
  assign w_fetch          = !branch_taken && !stall;
  assign w_unused_tgt_lsb = branch_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= c_pc_rst;
      r_instr <= c_nop;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall; the instruction being fetched is squashed.
      r_pc    <= w_branch_pc;
      r_instr <= c_nop;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_pc_plus4;
      r_instr <= imem_rdata;
      r_pc4   <= w_pc_plus4;
      r_valid <= 1'b1;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (w_fetch && (r_fetch_cnt != 16'hFFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
      if (branch_taken && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign flush_count = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// tb_if_stage: scoreboard bench for if_stage; expected state is queued at stimulus time.
// Revision: 1.0
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h8C08_0004;
    if (a == 32'h0000_0004) return 32'hAC08_0008;
    return {a[15:0] ^ 16'h5A3C, a[17:2]};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] fc;
    logic [15:0] flc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_fc, m_flc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_fc = 16'h0; m_flc = 16'h0;
    sb.delete();
  endtask

  // Applies inputs at the current negedge and queues the state expected after the next posedge.
  task automatic drive(input logic st, input logic br, input logic [31:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    if (br) begin
      m_pc = {tgt[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_flc != 16'hFFFF) m_flc = m_flc + 16'd1;
    end else if (!st) begin
      m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
    sb.push_back('{m_pc, m_instr, m_pc4, m_valid, m_fc, m_flc});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();
    #2;
    n_cmp++;
    if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got addr=%h instr=%h pc4=%h v=%b, want 0/0/0/0",
               imem_addr, if_id_instr, if_id_pc4, if_id_valid);
    end
`ifdef IF_STAGE_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 16'h0 || flush_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_counters: got fc=%h flc=%h, want 0/0", fetch_count, flush_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_pc4 !== e.pc4 || if_id_valid !== e.valid
`ifdef IF_STAGE_PERF_CNT_EN
          || fetch_count !== e.fc || flush_count !== e.flc
`endif
         ) begin
        n_err++;
        $display("FAIL seq_fetch[%0d]: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=%b",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (if_id_instr !== 32'hAC08_0008 || if_id_pc4 !== 32'h8 || imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL seq_fetch_final: got instr=%h pc4=%h addr=%h, want ac080008/8/8",
               if_id_instr, if_id_pc4, imem_addr);
    end
  endtask

  task automatic test_stall();
    logic st_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(st_tab[i], 1'b0, 32'h0);
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_pc4 !== e.pc4 || if_id_valid !== e.valid
`ifdef IF_STAGE_PERF_CNT_EN
          || fetch_count !== e.fc || flush_count !== e.flc
`endif
         ) begin
        n_err++;
        $display("FAIL stall[%0d]: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=%b",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
      if (st_tab[i]) begin
        n_cmp++;
        if (imem_addr !== 32'h10) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: got addr=%h, want 00000010", i, imem_addr);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (imem_addr !== 32'h14) begin
      n_err++;
      $display("FAIL stall_release: got addr=%h, want 00000014", imem_addr);
    end
  endtask

  task automatic test_branch_over_stall();
    logic        st_tab [2] = '{1'b1, 1'b0};
    logic        br_tab [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(st_tab[i], br_tab[i], 32'h0000_0043);
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_pc4 !== e.pc4 || if_id_valid !== e.valid
`ifdef IF_STAGE_PERF_CNT_EN
          || fetch_count !== e.fc || flush_count !== e.flc
`endif
         ) begin
        n_err++;
        $display("FAIL branch_over_stall[%0d]: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=%b",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (if_id_instr !== mem_word(32'h40) || if_id_valid !== 1'b1 || if_id_pc4 !== 32'h44) begin
      n_err++;
      $display("FAIL branch_target_fetch: got instr=%h v=%b pc4=%h, want instr=%h v=1 pc4=00000044",
               if_id_instr, if_id_valid, if_id_pc4, mem_word(32'h40));
    end
  endtask

  task automatic test_back_to_back();
    logic        br_tab  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tgt_tab [4] = '{32'h0000_0100, 32'h0000_0205, 32'h0000_0300, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, br_tab[i], tgt_tab[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_pc4 !== e.pc4 || if_id_valid !== e.valid
`ifdef IF_STAGE_PERF_CNT_EN
          || fetch_count !== e.fc || flush_count !== e.flc
`endif
         ) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=%b",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic br_tab [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, br_tab[i], 32'hFFFF_FFFC);
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_pc4 !== e.pc4 || if_id_valid !== e.valid
`ifdef IF_STAGE_PERF_CNT_EN
          || fetch_count !== e.fc || flush_count !== e.flc
`endif
         ) begin
        n_err++;
        $display("FAIL wrap[%0d]: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=%b",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
      if (i == 1) begin
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0) begin
          n_err++;
          $display("FAIL wrap_zero: got addr=%h pc4=%h, want 0/0", imem_addr, if_id_pc4);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0800;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got addr=%h instr=%h pc4=%h v=%b, want 0/0/0/0",
               imem_addr, if_id_instr, if_id_pc4, if_id_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_pc4 !== e.pc4 || if_id_valid !== e.valid
`ifdef IF_STAGE_PERF_CNT_EN
        || fetch_count !== e.fc || flush_count !== e.flc
`endif
       ) begin
      n_err++;
      $display("FAIL reset_first_fetch: got addr=%h instr=%h pc4=%h v=%b, want addr=%h instr=%h pc4=%h v=%b",
               imem_addr, if_id_instr, if_id_pc4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
    end
    @(negedge clk);
  endtask

`ifdef IF_STAGE_PERF_CNT_EN
  task automatic test_saturation();
    stall = 1'b0; branch_taken = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    n_cmp++;
    if (fetch_count !== 16'hFFFF || flush_count !== 16'h0000) begin
      n_err++;
      $display("FAIL counter_saturation: got fc=%h flc=%h, want ffff/0000", fetch_count, flush_count);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch_over_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef IF_STAGE_PERF_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
